// File: rtl/display_arb_pkg.sv
// Shared definitions for the textmode display-port arbiter.
// Holds the FSM state encoding, default bus widths and the default text attribute.
package display_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 16;

    // Light grey on black; callers OR this into the high byte of a write word.
    localparam logic [7:0] ATTR_DEFAULT = 8'h07;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RWAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/display_arb_pick.sv
// Two-way winner selection for the display-port arbiter (combinational).
// Ports: i_req0/i_req1 requests, i_last last winner (1 = requester 1),
//   i_starve forces requester 1 on a tie, o_win_vld any winner, o_win_sel winner id.
// Macro DISPLAY_ARB_FIXED_PRIO_EN: ties go to requester 0 unless i_starve is set.
module display_arb_pick (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    input  logic i_starve,
    output logic o_win_vld,
    output logic o_win_sel
);

    logic w_tie_sel;
    logic w_unused;

`ifdef DISPLAY_ARB_FIXED_PRIO_EN
    assign w_tie_sel = i_starve;
    assign w_unused  = i_last;
`else
    // Round-robin: whoever did not win last time takes the tie.
    assign w_tie_sel = ~i_last;
    assign w_unused  = i_starve;
`endif

    always_comb begin
        o_win_vld = i_req0 | i_req1;
        o_win_sel = 1'b0;
        unique case (1'b1)
            (i_req0 & i_req1):  o_win_sel = w_tie_sel;
            (i_req1 & ~i_req0): o_win_sel = 1'b1;
            default:            o_win_sel = 1'b0;
        endcase
    end

endmodule

// File: rtl/display_port_arbiter.sv
// Shares one textmode character-memory port between two requesters.
// Ports: clk, reset (async active-low); per requester reqN/weN/addrN/wdataN in,
//   gntN/rvalidN out; shared rdata out; mem_en/mem_wr/mem_addr/mem_wdata out,
//   mem_rdata in (one-cycle read latency); busy out (state != IDLE).
// Macro DISPLAY_ARB_FIXED_PRIO_EN: fixed priority to requester 0 with a
//   starvation counter that hands requester 1 a tie after STARVE_LIMIT losses.
module display_port_arbiter
    import display_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic                  r_last;
    logic                  r_sel;
    logic                  r_gnt0;
    logic                  r_gnt1;
    logic                  r_rvalid0;
    logic                  r_rvalid1;
    logic                  r_mem_en;
    logic                  r_mem_wr;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_busy;

    logic w_win_vld;
    logic w_win_sel;
    logic w_take;
    logic w_starve;

    display_arb_pick u_pick (
        .i_req0    (req0),
        .i_req1    (req1),
        .i_last    (r_last),
        .i_starve  (w_starve),
        .o_win_vld (w_win_vld),
        .o_win_sel (w_win_sel)
    );

    // Arbitration only happens in IDLE; requests seen in ISSUE/RWAIT are ignored.
    assign w_take = (r_state == S_IDLE) && w_win_vld;

`ifdef DISPLAY_ARB_FIXED_PRIO_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] r_loss;

    assign w_starve = (r_loss == CW'(STARVE_LIMIT));

    // Saturating count of arbitrations requester 1 wanted but lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_loss <= '0;
        end else if (w_take) begin
            if (w_win_sel) begin
                r_loss <= '0;
            end else if (req1 && !w_starve) begin
                r_loss <= r_loss + 1'b1;
            end
        end
    end
`else
    localparam int unused_starve_limit = STARVE_LIMIT;

    assign w_starve = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_mem_wr is still the registered 'we' while in ISSUE.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_win_vld) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = r_mem_wr ? S_IDLE : S_RWAIT;
            S_RWAIT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed one cycle early so they leave straight from flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last      <= 1'b1;
            r_sel       <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_mem_en  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_busy    <= (w_state_nxt != S_IDLE);
            if (w_take) begin
                r_sel       <= w_win_sel;
                r_last      <= w_win_sel;
                r_gnt0      <= ~w_win_sel;
                r_gnt1      <= w_win_sel;
                r_mem_en    <= 1'b1;
                r_mem_wr    <= w_win_sel ? we1 : we0;
                r_mem_addr  <= w_win_sel ? addr1 : addr0;
                r_mem_wdata <= w_win_sel ? wdata1 : wdata0;
            end
            if ((r_state == S_ISSUE) && !r_mem_wr) begin
                r_rvalid0 <= ~r_sel;
                r_rvalid1 <= r_sel;
            end
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_display_port_arbiter.sv
// Scoreboard bench for display_port_arbiter with a transaction-level reference.
// Directed cases plus randomized two-requester traffic.
module tb_display_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_wr, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    display_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .gnt0      (gnt0),
        .rvalid0   (rvalid0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt1      (gnt1),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Character memory device: one-cycle registered read.
    logic [DW-1:0] memdev [0:4095];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) memdev[mem_addr] <= mem_wdata;
            else        mem_rdata <= memdev[mem_addr];
        end
    end

    // Reference model: an access occupies the port for 2 cycles (write) or
    // 3 cycles (read); while free, a request sampled at a clock edge is accepted.
    typedef struct {
        bit            who;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    logic [DW-1:0] ref_mem [0:4095];
    txn_t exp_q[$];
    int   busy_left = 0;
    bit   last_win = 1'b1;
    int   loss = 0;
    bit   exp_busy = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_left = 0;
            last_win  = 1'b1;
            loss      = 0;
            exp_busy  = 1'b0;
            exp_q.delete();
        end else begin
            if (busy_left > 0) begin
                busy_left--;
            end else if (req0 || req1) begin
                txn_t t;
                bit   w;
                if (req0 && req1) begin
`ifdef DISPLAY_ARB_FIXED_PRIO_EN
                    w = (loss == LIMIT);
`else
                    w = !last_win;
`endif
                end else begin
                    w = req1;
                end
`ifdef DISPLAY_ARB_FIXED_PRIO_EN
                if (w) loss = 0;
                else if (req1 && loss < LIMIT) loss++;
`endif
                last_win = w;
                t.who   = w;
                t.we    = w ? we1 : we0;
                t.addr  = w ? addr1 : addr0;
                t.wdata = w ? wdata1 : wdata0;
                t.rdata = '0;
                if (t.we) ref_mem[t.addr] = t.wdata;
                else      t.rdata = ref_mem[t.addr];
                exp_q.push_back(t);
                busy_left = t.we ? 1 : 2;
            end
            exp_busy = (busy_left != 0);
        end
    end

    // Monitor: pops an expectation whenever the DUT presents an access.
    bit   pend_rv = 1'b0;
    txn_t pend_t;
    bit   gnt_log[$];

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_ctrl", {25'd0, gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_wr, busy}, 0);
            chk("rst_addr", {20'd0, mem_addr}, 0);
            chk("rst_wdata", {16'd0, mem_wdata}, 0);
            pend_rv = 1'b0;
        end else begin
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
            chk("gnt_excl", {31'd0, gnt0 & gnt1}, 0);
            chk("rv_excl", {31'd0, rvalid0 & rvalid1}, 0);
            if (pend_rv) begin
                chk("rvalid_who", {30'd0, rvalid1, rvalid0},
                    pend_t.who ? 32'd2 : 32'd1);
                chk("rdata", {16'd0, rdata}, {16'd0, pend_t.rdata});
            end else if (rvalid0 || rvalid1) begin
                chk("rvalid_spurious", {30'd0, rvalid1, rvalid0}, 0);
            end
            pend_rv = 1'b0;
            if (mem_en || gnt0 || gnt1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_access", {29'd0, mem_en, gnt1, gnt0}, 0);
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    chk("gnt_who", {30'd0, gnt1, gnt0}, t.who ? 32'd2 : 32'd1);
                    chk("mem_en_wr", {30'd0, mem_en, mem_wr}, {30'd1, t.we});
                    chk("mem_addr", {20'd0, mem_addr}, {20'd0, t.addr});
                    if (t.we) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, t.wdata});
                    gnt_log.push_back(gnt1);
                    if (!t.we) begin
                        pend_rv = 1'b1;
                        pend_t  = t;
                    end
                end
            end
        end
    end

    // Present one request and hold it until its grant is seen.
    task automatic drive(input bit who, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        int n = 0;
        bit got = 1'b0;
        if (who) begin
            we1 = we; addr1 = a; wdata1 = d; req1 = 1'b1;
        end else begin
            we0 = we; addr0 = a; wdata0 = d; req0 = 1'b1;
        end
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            got = who ? gnt1 : gnt0;
        end
        chk(who ? "grant_wait1" : "grant_wait0", {31'd0, got}, 1);
        if (who) req1 = 1'b0;
        else     req0 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        for (int i = 0; i < 4096; i++) begin
            logic [DW-1:0] v;
            v = DW'($urandom);
            memdev[i]  = v;
            ref_mem[i] = v;
        end
        memdev[12'h7FF]  = 16'h1234;
        ref_mem[12'h7FF] = 16'h1234;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Single write from requester 0.
        drive(1'b0, 1'b1, 12'h041, 16'h0741);
        idle(2);

        // Single read from requester 1.
        drive(1'b1, 1'b0, 12'h7FF, 16'h0000);
        idle(3);

        // Both requesters writing back-to-back.
`ifdef DISPLAY_ARB_FIXED_PRIO_EN
        c0 = 8; c1 = 2;
`else
        c0 = 5; c1 = 5;
`endif
        gnt_log.delete();
        fork
            begin
                for (int i = 0; i < c0; i++)
                    drive(1'b0, 1'b1, AW'($urandom), DW'($urandom));
            end
            begin
                for (int j = 0; j < c1; j++)
                    drive(1'b1, 1'b1, AW'($urandom), DW'($urandom));
            end
        join
        idle(3);
        chk("order_len", {31'd0, gnt_log.size() >= 10}, 1);
        if (gnt_log.size() >= 10) begin
            for (int i = 0; i < 10; i++) begin
`ifdef DISPLAY_ARB_FIXED_PRIO_EN
                chk("gnt_order", {31'd0, gnt_log[i]}, {31'd0, (i % 5) == 4});
`else
                chk("gnt_order", {31'd0, gnt_log[i]}, 32'(i % 2));
`endif
            end
        end

        // Reset pulsed while a read sits in RWAIT.
        drive(1'b0, 1'b0, 12'h123, 16'h0000);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b1, 12'h200, 16'h0755);
        idle(3);

        // Request raised and withdrawn before it can be granted.
        drive(1'b1, 1'b0, 12'h010, 16'h0000);
        we0 = 1'b0; addr0 = 12'h0AA; req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        idle(4);

        // Random traffic from both sides.
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    drive(1'b0, 1'($urandom), AW'($urandom_range(0, 31)), DW'($urandom));
                    idle($urandom_range(0, 2));
                end
            end
            begin
                for (int j = 0; j < 30; j++) begin
                    drive(1'b1, 1'($urandom), AW'($urandom_range(0, 31)), DW'($urandom));
                    idle($urandom_range(0, 2));
                end
            end
        join
        idle(5);

        chk("queue_empty", exp_q.size(), 0);
        chk("rv_pending", {31'd0, pend_rv}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/display_port_arbiter.md
Name: display_port_arbiter

Overview:
Shares one textmode character-memory port (ADDR = {row[4:0], col[6:0]}, 16-bit attr+char word) between two requesters, e.g. the I-CPU and O-CPU port decoders.
- Arbitration: round-robin, one access at a time.
- Reads: absorbs the memory's one-cycle read latency and returns the data with an explicit rvalid strobe.
- Placement: between the CPU I/O decode logic and textmode_display's dsp_* port.

Parameters:
ADDR_WIDTH, 12, character memory address width ({row, col}).
DATA_WIDTH, 16, memory word width ({attr[7:0], char[7:0]}).
STARVE_LIMIT, 4, consecutive losses before requester 1 is forced to win (used only with the optional feature).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req0  in  1  requester 0 access request; held until gnt0
we0  in  1  requester 0 write (1) / read (0)
addr0  in  ADDR_WIDTH  requester 0 address
wdata0  in  DATA_WIDTH  requester 0 write data
gnt0  out  1  one-cycle grant pulse to requester 0
rvalid0  out  1  one-cycle read-data-valid to requester 0
req1, we1, addr1, wdata1, gnt1, rvalid1  as above, for requester 1
rdata  out  DATA_WIDTH  read data, shared by both requesters; qualified by rvalid0/rvalid1
mem_en  out  1  memory access enable (maps to dsp_en)
mem_wr  out  1  memory write (maps to dsp_wr)
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data; valid the cycle after mem_en & ~mem_wr
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset low, asynchronous):
  - State = IDLE; last-winner pointer = 1, so requester 0 wins the first tie.
  - gnt*, rvalid*, mem_en, mem_wr and busy = 0; mem_addr, mem_wdata = 0.
- States: IDLE, ISSUE, RWAIT.
- IDLE, cycle N:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, that requester wins.
  - If both are high, the winner is the one that is not the last-winner pointer.
  - On a win: register we/addr/wdata of the winner, update the pointer, go to ISSUE.
- ISSUE, cycle N+1:
  - mem_en = 1, mem_wr = registered we, mem_addr/mem_wdata = registered values.
  - gnt of the winner = 1.
  - Next state is IDLE for a write, RWAIT for a read.
  - No arbitration happens in this state; a req still high in this cycle is ignored.
- RWAIT, cycle N+2:
  - rdata = mem_rdata (combinational passthrough); rvalid of the winner = 1.
  - Next state is IDLE.
- Latency and throughput:
  - Write: req sampled at N, gnt and memory write at N+1. One write per 2 cycles.
  - Read: gnt at N+1, rvalid at N+2. One read per 3 cycles.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt is sampled high.
  - May drop req, or present a new request, in the cycle after gnt.
  - A req dropped before its grant produces no access.
- rdata outside rvalid: don't-care, but must equal mem_rdata.
- Mutual exclusion: gnt0 & gnt1 and rvalid0 & rvalid1 are never both 1.
- Outputs: all are registered except rdata.
- Reset asserted mid-ISSUE or mid-RWAIT: the access is abandoned and no gnt or rvalid is emitted afterwards. A write already presented on mem_* in that cycle may or may not complete.

Optional Feature:
DISPLAY_ARB_FIXED_PRIO_EN
- Defined:
  - Requester 0 always wins ties.
  - A saturating loss counter counts the IDLE cycles in which req1 is high and requester 0 wins.
  - When the counter equals STARVE_LIMIT, requester 1 wins the next tie and the counter clears.
  - The counter also clears whenever requester 1 wins, and on reset.
- Undefined: round-robin as specified above; no counter logic is present.

Decomposition:
- Shared package display_arb_pkg:
  - state encoding localparams S_IDLE/S_ISSUE/S_RWAIT;
  - default widths ADDR_WIDTH=12 and DATA_WIDTH=16;
  - the ATTR_DEFAULT=8'h07 constant used by callers.
- One sub-module: display_arb_pick, a combinational two-way winner selection from req0, req1, the pointer and the (optional) starve flag. The FSM and datapath registers stay in the top module.

Test Plan:
1. Reset release, req0=1, we0=1, addr0=12'h041, wdata0=16'h0741 at N -> gnt0=1, mem_en=1, mem_wr=1, mem_addr=12'h041, mem_wdata=16'h0741 at N+1; busy=0 at N+2.
2. Read req1=1, we1=0, addr1=12'h7FF; model returns 16'h1234 -> gnt1 at N+1, rvalid1=1 and rdata=16'h1234 at N+2, rvalid0 stays 0.
3. req0 and req1 held high continuously, both writes -> grants alternate 0,1,0,1 every 2 cycles; gnt0 & gnt1 never both 1.
4. Read granted at N+1, reset pulsed low during N+2 -> rvalid* stays 0; state is IDLE after release; the next req0 is granted normally.
5. req0 raised then dropped before its grant cycle while a read is in RWAIT -> no mem_en for requester 0.
6. DISPLAY_ARB_FIXED_PRIO_EN with STARVE_LIMIT=4, both requesters writing continuously -> grant order 0,0,0,0,1, repeating.
